// File: rtl/latency_ram.sv
// Word-addressed 32-bit RAM with a programmable wait latency before each ACCESS,
// plus a backdoor preload/dump port and saturating read/write completion counters.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

module latency_ram
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned LAT    = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  input  logic        ramREN,
  input  logic        ramWEN,
  output logic [31:0] ramload,
  output ramstate_t   ramstate,
  input  logic        tb_WEN,
  input  logic [31:0] tb_addr,
  input  logic [31:0] tb_data,
  output logic [31:0] tb_rdata,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = (LAT == 0) ? 1 : $clog2(LAT + 1);
  localparam int unsigned DW    = 32;

  logic [DW-1:0]     mem [DEPTH];

  logic              pend, pend_n;
  logic [31:0]       lat_addr, lat_addr_n;
  logic              lat_wr, lat_wr_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [31:0]       rd_count_n, wr_count_n;

  logic [ADDR_W-1:0] bus_idx;
  logic [ADDR_W-1:0] tb_idx;
  logic [ADDR_W-1:0] lat_idx;
  logic              match_c;
  logic              mem_we_c;
  ramstate_t         state_c;

  // Byte addresses alias: low two bits and everything above the index are dropped
  assign bus_idx = ramaddr[ADDR_W+1:2];
  assign tb_idx  = tb_addr[ADDR_W+1:2];
  assign lat_idx = lat_addr[ADDR_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ramaddr[1:0], ramaddr[31:ADDR_W+2],
                              tb_addr[1:0], tb_addr[31:ADDR_W+2],
                              lat_addr[1:0], lat_addr[31:ADDR_W+2]};

  // The pending request is only still valid if address index and op are unchanged
  assign match_c = pend && (bus_idx == lat_idx) && (ramWEN == lat_wr);

  always_comb begin
    state_c = BUSY;
    if (ramREN && ramWEN) begin
      state_c = ERROR;
    end else if (!ramREN && !ramWEN) begin
      state_c = FREE;
    end else if (match_c && (cnt == CNT_W'(LAT))) begin
      state_c = ACCESS;
    end
  end

  assign ramstate = state_c;
  assign ramload  = ((state_c == ACCESS) && ramREN) ? mem[bus_idx] : '0;
  assign tb_rdata = mem[tb_idx];

  // Next-state for the latency tracker and counters
  always_comb begin
    pend_n     = pend;
    lat_addr_n = lat_addr;
    lat_wr_n   = lat_wr;
    cnt_n      = cnt;
    rd_count_n = rd_count;
    wr_count_n = wr_count;
    mem_we_c   = 1'b0;
    unique case (state_c)
      FREE: begin
        pend_n = 1'b0;
      end
      ERROR: begin
        pend_n = 1'b0;
      end
      BUSY: begin
        if (!match_c) begin
          pend_n     = 1'b1;
          lat_addr_n = ramaddr;
          lat_wr_n   = ramWEN;
          cnt_n      = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ACCESS: begin
        pend_n = 1'b0;
        if (ramWEN) begin
          mem_we_c = 1'b1;
          if (wr_count != 32'hFFFF_FFFF) wr_count_n = wr_count + 32'd1;
        end else begin
          if (rd_count != 32'hFFFF_FFFF) rd_count_n = rd_count + 32'd1;
        end
      end
      default: begin
        pend_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pend     <= 1'b0;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
      cnt      <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      pend     <= pend_n;
      lat_addr <= lat_addr_n;
      lat_wr   <= lat_wr_n;
      cnt      <= cnt_n;
      rd_count <= rd_count_n;
      wr_count <= wr_count_n;
    end
  end

  // Storage is never reset; the later bus write overrides a same-index backdoor write
  always_ff @(posedge CLK) begin
    if (tb_WEN) mem[tb_idx] <= tb_data;
    if (mem_we_c) mem[bus_idx] <= ramstore;
  end

endmodule
